// File: rtl/mul_div_controller_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mul_div_controller_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

  function automatic logic is_div(input op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// One iteration of shift-add multiply or restoring divide on unsigned magnitudes.
module mul_div_step
  import mul_div_controller_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] mq_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
    rem_sh  = {acc, mq[WIDTH-1]};
    diff    = rem_sh - {1'b0, opnd};
    acc_nxt = '0;
    mq_nxt  = '0;
    if (is_div(op)) begin
      // Remainder stays below the divisor, so the dropped top bit of rem_sh is
      // only ever set when the subtraction succeeds.
      if (!diff[WIDTH]) begin
        acc_nxt = diff[WIDTH-1:0];
        mq_nxt  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem_sh[WIDTH-1:0];
        mq_nxt  = {mq[WIDTH-2:0], 1'b0};
      end
    end else begin
      {acc_nxt, mq_nxt} = {sum, mq[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_controller.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO, with hazard stall output.
module mul_div_controller
  import mul_div_controller_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_e,
  input  logic [1:0]       op_e,
  input  logic [WIDTH-1:0] src_a_e,
  input  logic [WIDTH-1:0] src_b_e,
  input  logic             read_hilo_d,
  input  logic             flush,
  output logic             busy,
  output logic             hilo_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done,
  output logic             div_by_zero
);

  state_t             state, state_nxt;
  op_t                op_in, op_q;
  logic [CNT_W-1:0]   cnt;
  logic               neg_q, neg_r;
  logic [WIDTH-1:0]   acc, mq, opnd;
  logic [WIDTH-1:0]   acc_step, mq_step;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               accept, zero_div;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_in    = op_t'(op_e);
  assign accept   = start_e && (state == ST_IDLE) && !flush;
  assign zero_div = accept && is_div(op_in) && (src_b_e == '0);

  assign mag_a = (is_signed_op(op_in) && src_a_e[WIDTH-1]) ? -src_a_e : src_a_e;
  assign mag_b = (is_signed_op(op_in) && src_b_e[WIDTH-1]) ? -src_b_e : src_b_e;

  assign busy       = (state == ST_RUN) || (state == ST_FIX);
  assign hilo_stall = busy && read_hilo_d;

  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .acc     (acc),
    .mq      (mq),
    .opnd    (opnd),
    .acc_nxt (acc_step),
    .mq_nxt  (mq_step)
  );

  always_comb begin
    prod_fix = neg_q ? -{acc, mq} : {acc, mq};
    quo_fix  = neg_q ? -mq : mq;
    rem_fix  = neg_r ? -acc : acc;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept && !zero_div) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == CNT_W'(WIDTH - 1)) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_q        <= OP_MULT;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      acc         <= '0;
      mq          <= '0;
      opnd        <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      done        <= 1'b0;
      div_by_zero <= zero_div;
      if (accept) begin
        op_q  <= op_in;
        neg_q <= is_signed_op(op_in) && (src_a_e[WIDTH-1] ^ src_b_e[WIDTH-1]);
        neg_r <= is_signed_op(op_in) && src_a_e[WIDTH-1];
        acc   <= '0;
        mq    <= mag_a;
        opnd  <= mag_b;
        cnt   <= '0;
      end
      if ((state == ST_RUN) && !flush) begin
        acc <= acc_step;
        mq  <= mq_step;
        cnt <= cnt + 1'b1;
      end
      if ((state == ST_FIX) && !flush) begin
        if (is_div(op_q)) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
        done <= 1'b1;
      end
    end
  end

endmodule
